// File: rtl/dtlb_buffer_nway.sv
// N-entry fully-associative data micro-TLB for the MEM stage.
// Hits translate combinationally; misses are refilled from the main TLB through an IDLE/LOOKUP/FILL sequence.
module dtlb_buffer_nway #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ASID_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [31:0]       vaddr,
  input  logic [ASID_W-1:0] cur_asid,
  input  logic [2:0]        cfg_k0,
  output logic [31:0]       paddr,
  output logic              is_cached,
  output logic              trans_ok,
  output logic              stall,
  output logic [2:0]        exc_code,
  output logic [18:0]       tlb_vpn2,
  input  logic              tlb_found,
  input  logic [ASID_W+69:0] tlb_entry
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  localparam logic [2:0] EXC_NONE  = 3'd0;
  localparam logic [2:0] EXC_REF_L = 3'd1;
  localparam logic [2:0] EXC_REF_S = 3'd2;
  localparam logic [2:0] EXC_INV_L = 3'd3;
  localparam logic [2:0] EXC_INV_S = 3'd4;
  localparam logic [2:0] EXC_MOD   = 3'd5;

  typedef struct packed {
    logic [18:0]       vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [19:0]       pfn0;
    logic [2:0]        c0;
    logic              d0;
    logic              v0;
    logic [19:0]       pfn1;
    logic [2:0]        c1;
    logic              d1;
    logic              v1;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_FILL   = 2'd2
  } state_t;

  state_t            r_state;
  entry_t            r_ent [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [IDX_W-1:0]  r_rr;
  logic [18:0]       r_vpn2;
  logic [ASID_W-1:0] r_asid;
  logic              r_found;
  entry_t            r_fill;
  logic              r_rec_valid;
  logic [18:0]       r_rec_vpn2;
  logic [ASID_W-1:0] r_rec_asid;

  logic [DEPTH-1:0]  w_hit;
  logic              w_hit_any;
  entry_t            w_sel;
  logic              w_unmapped;
  logic              w_idle;
  logic              w_rec_match;
  logic              w_start;
  logic [19:0]       w_pfn;
  logic [2:0]        w_c;
  logic              w_d;
  logic              w_v;
  logic              w_inplace;
  logic [IDX_W-1:0]  w_inplace_idx;
  logic              w_free;
  logic [IDX_W-1:0]  w_free_idx;
  logic [IDX_W-1:0]  w_victim;
  logic              w_replace;

  assign w_unmapped  = (vaddr[31:30] == 2'b10);
  assign w_idle      = (r_state == S_IDLE);
  assign w_rec_match = r_rec_valid && (r_rec_vpn2 == vaddr[31:13]) && (r_rec_asid == cur_asid);

  // Associative match; at most one entry may hit.
  always_comb begin
    w_hit     = '0;
    w_hit_any = 1'b0;
    w_sel     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_hit[i] = r_valid[i] && (r_ent[i].vpn2 == vaddr[31:13]) &&
                 (r_ent[i].g || (r_ent[i].asid == cur_asid));
      if (w_hit[i]) begin
        w_hit_any = 1'b1;
        w_sel     = r_ent[i];
      end
    end
  end

  assign w_pfn = vaddr[12] ? w_sel.pfn1 : w_sel.pfn0;
  assign w_c   = vaddr[12] ? w_sel.c1   : w_sel.c0;
  assign w_d   = vaddr[12] ? w_sel.d1   : w_sel.d0;
  assign w_v   = vaddr[12] ? w_sel.v1   : w_sel.v0;

  assign w_start = w_idle && req_valid && !w_unmapped && !w_hit_any && !w_rec_match;

  // Translation result; suppressed while a refill is in flight.
  always_comb begin
    paddr     = '0;
    is_cached = 1'b0;
    trans_ok  = 1'b0;
    exc_code  = EXC_NONE;
    if (req_valid && w_idle) begin
      if (w_unmapped) begin
        paddr     = {3'b000, vaddr[28:0]};
        is_cached = !vaddr[29] && (cfg_k0 == 3'd3);
        trans_ok  = 1'b1;
      end else if (w_hit_any) begin
        paddr     = {w_pfn, vaddr[11:0]};
        is_cached = (w_c == 3'd3);
        if (!w_v) begin
          exc_code = req_store ? EXC_INV_S : EXC_INV_L;
        end else if (req_store && !w_d) begin
          exc_code = EXC_MOD;
        end else begin
          trans_ok = 1'b1;
        end
      end else if (w_rec_match) begin
        exc_code = req_store ? EXC_REF_S : EXC_REF_L;
      end
    end
  end

  assign stall    = w_start || !w_idle;
  assign tlb_vpn2 = (r_state == S_LOOKUP) ? r_vpn2 : vaddr[31:13];

  // Victim: same vpn2/asid in place, else lowest free slot, else round-robin.
  always_comb begin
    w_inplace     = 1'b0;
    w_inplace_idx = '0;
    w_free        = 1'b0;
    w_free_idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!w_inplace && r_valid[i] && (r_ent[i].vpn2 == r_fill.vpn2) &&
          (r_ent[i].asid == r_fill.asid)) begin
        w_inplace     = 1'b1;
        w_inplace_idx = IDX_W'(i);
      end
      if (!w_free && !r_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_replace = !w_inplace && !w_free;
  assign w_victim  = w_inplace ? w_inplace_idx : (w_free ? w_free_idx : r_rr);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_rr        <= '0;
      r_vpn2      <= '0;
      r_asid      <= '0;
      r_found     <= 1'b0;
      r_fill      <= '0;
      r_rec_valid <= 1'b0;
      r_rec_vpn2  <= '0;
      r_rec_asid  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_ent[i] <= '0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_rec_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_vpn2  <= vaddr[31:13];
            r_asid  <= cur_asid;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_found <= tlb_found;
          r_fill  <= tlb_entry;
          r_state <= S_FILL;
        end
        S_FILL: begin
          if (r_found) begin
            r_ent[w_victim]   <= r_fill;
            r_valid[w_victim] <= 1'b1;
            if (w_replace) r_rr <= (r_rr == IDX_W'(DEPTH - 1)) ? '0 : r_rr + 1'b1;
          end else begin
            r_rec_valid <= 1'b1;
            r_rec_vpn2  <= r_vpn2;
            r_rec_asid  <= r_asid;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  a_single_hit: assert property (@(posedge clk) disable iff (!resetn) $onehot0(w_hit));

endmodule

// File: tb/tb_dtlb_buffer_nway.sv
// Randomized bench for dtlb_buffer_nway against a transaction-level micro-TLB model
// fed by a behavioural main-TLB table.
module tb_dtlb_buffer_nway;

  localparam int unsigned DEPTH = 4;
  localparam int NP = 8;

  logic        clk = 1'b0;
  logic        resetn, flush, req_valid, req_store;
  logic [31:0] vaddr;
  logic [7:0]  cur_asid;
  logic [2:0]  cfg_k0;
  logic [31:0] paddr;
  logic        is_cached, trans_ok, stall;
  logic [2:0]  exc_code;
  logic [18:0] tlb_vpn2;
  logic        tlb_found;
  logic [77:0] tlb_entry;

  always #5 clk = ~clk;

  dtlb_buffer_nway #(.DEPTH(DEPTH), .ASID_W(8)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .req_valid(req_valid),
    .req_store(req_store), .vaddr(vaddr), .cur_asid(cur_asid), .cfg_k0(cfg_k0),
    .paddr(paddr), .is_cached(is_cached), .trans_ok(trans_ok), .stall(stall),
    .exc_code(exc_code), .tlb_vpn2(tlb_vpn2), .tlb_found(tlb_found), .tlb_entry(tlb_entry)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Main TLB contents: per page index, g is fixed; found depends on asid; data per half.
  logic [18:0] pool_vpn [NP];
  bit          mt_g     [NP];
  bit          mt_found [NP][2];
  logic [19:0] mt_pfn   [NP][2];
  logic [2:0]  mt_c     [NP][2];
  bit          mt_d     [NP][2];
  bit          mt_v     [NP][2];
  logic [7:0]  asid_tab [2];
  int          cur_ai;

  // Micro-TLB reference state
  bit          m_valid [DEPTH];
  int          m_pidx  [DEPTH];
  logic [7:0]  m_asid  [DEPTH];
  int          m_rr;
  bit          m_rec_valid;
  logic [18:0] m_rec_vpn;
  logic [7:0]  m_rec_asid;
  int          m_hit_i;

  always_comb begin
    tlb_found = 1'b0;
    tlb_entry = '0;
    for (int p = 0; p < NP; p++) begin
      if (pool_vpn[p] == tlb_vpn2) begin
        tlb_found = mt_found[p][cur_ai];
        tlb_entry = {pool_vpn[p], cur_asid, mt_g[p],
                     mt_pfn[p][0], mt_c[p][0], mt_d[p][0], mt_v[p][0],
                     mt_pfn[p][1], mt_c[p][1], mt_d[p][1], mt_v[p][1]};
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, want);
    end
  endtask

  function automatic int pidx_of(input logic [18:0] vpn);
    int r = -1;
    for (int p = 0; p < NP; p++) if (pool_vpn[p] == vpn) r = p;
    return r;
  endfunction

  // 0 unmapped, 1 hit, 2 miss-record match, 3 miss
  function automatic int classify(input logic [31:0] va);
    logic [18:0] vpn = va[31:13];
    if (va[31:30] == 2'b10) return 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (m_valid[i] && pool_vpn[m_pidx[i]] == vpn && (mt_g[m_pidx[i]] || m_asid[i] == cur_asid)) begin
        m_hit_i = i;
        return 1;
      end
    end
    if (m_rec_valid && m_rec_vpn == vpn && m_rec_asid == cur_asid) return 2;
    return 3;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) m_valid[i] = 0;
    m_rec_valid = 0;
  endtask

  task automatic model_fill(input logic [31:0] va);
    int p = pidx_of(va[31:13]);
    int slot = -1;
    if (p >= 0 && mt_found[p][cur_ai]) begin
      for (int i = 0; i < int'(DEPTH); i++)
        if (slot < 0 && m_valid[i] && m_pidx[i] == p && m_asid[i] == cur_asid) slot = i;
      for (int i = 0; i < int'(DEPTH); i++)
        if (slot < 0 && !m_valid[i]) slot = i;
      if (slot < 0) begin
        slot = m_rr;
        m_rr = (m_rr + 1) % int'(DEPTH);
      end
      m_valid[slot] = 1;
      m_pidx[slot]  = p;
      m_asid[slot]  = cur_asid;
    end else begin
      m_rec_valid = 1;
      m_rec_vpn   = va[31:13];
      m_rec_asid  = cur_asid;
    end
  endtask

  task automatic check_outputs(input logic [31:0] va, input bit st);
    int kind = classify(va);
    bit want_ok = 0, want_c = 0, want_stall = 0;
    logic [31:0] want_pa = 0;
    int want_exc = 0;
    case (kind)
      0: begin
        want_ok = 1;
        want_pa = va & 32'h1FFF_FFFF;
        want_c  = (va[29] == 1'b0) && (cfg_k0 == 3'd3);
      end
      1: begin
        int p = m_pidx[m_hit_i];
        int h = int'(va[12]);
        if (!mt_v[p][h]) want_exc = st ? 4 : 3;
        else if (st && !mt_d[p][h]) want_exc = 5;
        else begin
          want_ok = 1;
          want_pa = (32'(mt_pfn[p][h]) << 12) | (va & 32'h0000_0FFF);
          want_c  = (mt_c[p][h] == 3'd3);
        end
      end
      2: want_exc = st ? 2 : 1;
      default: want_stall = 1;
    endcase
    chk("trans_ok", 32'(trans_ok), 32'(want_ok));
    chk("exc_code", 32'(exc_code), 32'(want_exc));
    chk("stall", 32'(stall), 32'(want_stall));
    if (want_ok) begin
      chk("paddr", paddr, want_pa);
      chk("is_cached", 32'(is_cached), 32'(want_c));
    end
  endtask

  // One MEM-stage access; a miss is followed through LOOKUP and FILL to the replay.
  task automatic access(input logic [31:0] va, input bit st);
    @(negedge clk);
    req_valid = 1; vaddr = va; req_store = st;
    #1;
    if (classify(va) == 3) begin
      chk("stall_detect", 32'(stall), 32'd1);
      chk("no_exc_miss", 32'(exc_code), 32'd0);
      @(negedge clk); #1;
      chk("stall_lookup", 32'(stall), 32'd1);
      chk("tlb_vpn2", 32'(tlb_vpn2), 32'(va[31:13]));
      @(negedge clk); #1;
      chk("stall_fill", 32'(stall), 32'd1);
      model_fill(va);
      @(negedge clk); #1;
    end
    check_outputs(va, st);
  endtask

  task automatic do_flush();
    @(negedge clk);
    req_valid = 0; flush = 1;
    @(negedge clk);
    flush = 0;
    model_clear();
  endtask

  task automatic set_asid(input int ai);
    cur_ai = ai;
    cur_asid = asid_tab[ai];
  endtask

  task automatic set_page(input int p, input bit g, input bit f0, input bit f1,
                          input logic [19:0] pfn, input bit v, input bit d);
    mt_g[p] = g; mt_found[p][0] = f0; mt_found[p][1] = f1;
    for (int h = 0; h < 2; h++) begin
      mt_pfn[p][h] = pfn + 20'(h); mt_c[p][h] = 3'd3; mt_d[p][h] = d; mt_v[p][h] = v;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] va;
    asid_tab[0] = 8'h11; asid_tab[1] = 8'h22;
    set_asid(0);
    resetn = 0; flush = 0; req_valid = 0; req_store = 0; vaddr = 0; cfg_k0 = 3'd3;
    m_rr = 0; model_clear();
    for (int p = 0; p < NP; p++) begin
      pool_vpn[p] = 19'h200 + 19'(p * 16);
      set_page(p, 0, 1, 1, 20'h10000 + 20'(p * 256), 1, 1);
    end
    #12;
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_trans_ok", 32'(trans_ok), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_exc", 32'(exc_code), 32'd0);
    chk("rst_cached", 32'(is_cached), 32'd0);
    @(negedge clk); resetn = 1;

    // Unmapped kseg0 / kseg1
    access(32'h8000_1234, 0);
    chk("kseg0_paddr", paddr, 32'h0000_1234);
    access(32'hA000_0040, 0);
    cfg_k0 = 3'd2;
    access(32'h8000_0080, 1);
    cfg_k0 = 3'd3;

    // Cold load refill, then odd-half store permission cases
    set_page(0, 0, 1, 1, 20'h12345, 1, 1);
    mt_d[0][1] = 0;
    access(32'h0040_0010, 0);
    chk("cold_paddr", paddr, 32'h1234_5010);
    access(32'h0040_1000, 1);
    chk("modified", 32'(exc_code), 32'd5);
    mt_v[0][1] = 0;
    do_flush();
    access(32'h0040_1000, 1);
    chk("invalid_s", 32'(exc_code), 32'd4);

    // Not found in main TLB -> refill exception; flush forces new lookup
    set_page(1, 0, 0, 0, 20'h00AAA, 1, 1);
    va = {pool_vpn[1], 13'h0044};
    access(va, 0);
    access(va, 1);
    do_flush();
    access(va, 0);

    // Round-robin replacement across five and six fills
    do_flush();
    for (int p = 2; p < 8; p++) begin
      set_page(p, 0, 1, 1, 20'h30000 + 20'(p), 1, 1);
      access({pool_vpn[p], 13'h0100}, 0);
    end
    access({pool_vpn[2], 13'h0100}, 0);
    access({pool_vpn[3], 13'h0100}, 0);

    // Flush during FILL suppresses the write
    do_flush();
    va = {pool_vpn[4], 13'h0008};
    @(negedge clk); req_valid = 1; vaddr = va; req_store = 0; #1;
    chk("ff_stall0", 32'(stall), 32'd1);
    @(negedge clk);
    @(negedge clk); flush = 1; req_valid = 0;
    @(negedge clk); flush = 0; #1;
    chk("ff_stall_drop", 32'(stall), 32'd0);
    model_clear();
    access(va, 0);

    // Pipeline flush (req_valid low) during LOOKUP: fill completes silently
    va = {pool_vpn[5], 13'h1010};
    @(negedge clk); req_valid = 1; vaddr = va; #1;
    chk("rv_stall0", 32'(stall), 32'd1);
    @(negedge clk); req_valid = 0; #1;
    chk("rv_stall1", 32'(stall), 32'd1);
    chk("rv_exc1", 32'(exc_code), 32'd0);
    @(negedge clk); #1;
    chk("rv_stall2", 32'(stall), 32'd1);
    model_fill(va);
    @(negedge clk); #1;
    chk("rv_stall3", 32'(stall), 32'd0);
    access(va, 0);

    // ASID: g=0 entry misses under another ASID, g=1 hits
    do_flush();
    set_page(6, 0, 1, 1, 20'h44444, 1, 1);
    set_page(7, 1, 1, 1, 20'h55555, 1, 1);
    access({pool_vpn[6], 13'h0020}, 0);
    access({pool_vpn[7], 13'h0020}, 0);
    set_asid(1);
    access({pool_vpn[6], 13'h0020}, 0);
    access({pool_vpn[7], 13'h0024}, 0);
    set_asid(0);

    // Asynchronous reset in LOOKUP
    va = {pool_vpn[0], 13'h0000};
    @(negedge clk); req_valid = 1; vaddr = va; #1;
    @(negedge clk); req_valid = 0; resetn = 0; #1;
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_tlbvpn", 32'(tlb_vpn2), 32'(va[31:13]));
    model_clear(); m_rr = 0;
    @(negedge clk); resetn = 1;
    access(va, 0);

    // Randomized traffic over a fresh main-TLB table
    for (int p = 0; p < NP; p++) begin
      logic [1:0] top;
      top = (p % 3 == 0) ? 2'b00 : ((p % 3 == 1) ? 2'b01 : 2'b11);
      pool_vpn[p] = {top, 14'($urandom), 3'(p)};
      mt_g[p] = ($urandom_range(0, 3) == 0);
      for (int a = 0; a < 2; a++) mt_found[p][a] = ($urandom_range(0, 3) != 0);
      for (int h = 0; h < 2; h++) begin
        mt_pfn[p][h] = 20'($urandom);
        mt_c[p][h]   = $urandom_range(0, 1) ? 3'd3 : 3'd2;
        mt_d[p][h]   = 1'($urandom_range(0, 1));
        mt_v[p][h]   = ($urandom_range(0, 4) != 0);
      end
    end
    do_flush();
    for (int it = 0; it < 400; it++) begin
      int r = $urandom_range(0, 99);
      if (r < 6) do_flush();
      else if (r < 16) begin
        cfg_k0 = 3'($urandom);
        access({2'b10, 30'($urandom)}, 1'($urandom));
      end else if (r < 22) set_asid(int'($urandom_range(0, 1)));
      else begin
        int p = int'($urandom_range(0, NP - 1));
        access({pool_vpn[p], 13'($urandom)}, 1'($urandom));
      end
    end

    @(negedge clk); req_valid = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
